// File: rtl/mem_access_unit.sv
// CPU-to-DMEM load/store unit: IDLE->(RD)->(WR)->RESP; 2 cycles load/word store, 3 sub-word store, 1 error.
// req_ready only in IDLE, so one transaction is in flight at a time; DMEM is never stalled.
`ifndef SW_DMEM
`define SW_DMEM 2'b10
`endif
`ifndef LW_DMEM
`define LW_DMEM 3'b010
`endif

module mem_access_unit #(
  parameter int unsigned DMEM_WORDS = 2048
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        dm_cs,
  output logic        dm_r,
  output logic        dm_w,
  output logic [1:0]  dm_sc,
  output logic [2:0]  dm_lc,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata
);

  localparam logic [31:0] WORDS = 32'(DMEM_WORDS);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        cs_q, cs_d;
  logic        r_q, r_d;
  logic        w_q, w_d;
  logic [31:0] dm_wdata_q, dm_wdata_d;
  logic        req_err;

  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] off,
                                           input logic [1:0] sz, input logic uns);
    logic [31:0] s;
    s = word >> {off, 3'b000};
    case (sz)
      2'd0:    load_ext = uns ? {24'h0, s[7:0]}  : {{24{s[7]}}, s[7:0]};
      2'd1:    load_ext = uns ? {16'h0, s[15:0]} : {{16{s[15]}}, s[15:0]};
      default: load_ext = s;
    endcase
  endfunction

  // Only byte/half reach here; half alignment is guaranteed by the error check.
  function automatic logic [31:0] merge(input logic [31:0] word, input logic [31:0] wd,
                                        input logic [1:0] off, input logic [1:0] sz);
    logic [31:0] lane;
    lane  = (sz == 2'd0) ? 32'h0000_00FF : 32'h0000_FFFF;
    merge = (word & ~(lane << {off, 3'b000})) | ((wd & lane) << {off, 3'b000});
  endfunction

  assign req_err = (req_size == 2'd3)
                 | ((req_size == 2'd1) & req_addr[0])
                 | ((req_size == 2'd2) & (|req_addr[1:0]))
                 | ({2'b00, req_addr[31:2]} >= WORDS);

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    size_d       = size_q;
    uns_d        = uns_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = 32'h0;
    cs_d         = 1'b0;
    r_d          = 1'b0;
    w_d          = 1'b0;
    dm_wdata_d   = 32'h0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (req_err) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else if (req_we && req_size == 2'd2) begin
            state_d    = WR;
            cs_d       = 1'b1;
            w_d        = 1'b1;
            dm_wdata_d = req_wdata;
          end else begin
            state_d = RD;
            cs_d    = 1'b1;
            r_d     = 1'b1;
          end
        end
      end
      RD: begin
        // dm_rdata is consumed on the edge that leaves RD.
        if (we_q) begin
          state_d    = WR;
          cs_d       = 1'b1;
          w_d        = 1'b1;
          dm_wdata_d = merge(dm_rdata, wdata_q, addr_q[1:0], size_q);
        end else begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = load_ext(dm_rdata, addr_q[1:0], size_q, uns_q);
        end
      end
      WR: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      size_q       <= 2'd0;
      uns_q        <= 1'b0;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
      cs_q         <= 1'b0;
      r_q          <= 1'b0;
      w_q          <= 1'b0;
      dm_wdata_q   <= 32'h0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      cs_q         <= cs_d;
      r_q          <= r_d;
      w_q          <= w_d;
      dm_wdata_q   <= dm_wdata_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign dm_cs      = cs_q;
  assign dm_r       = r_q;
  // Combinational gate so a reset landing mid-WR cannot corrupt memory.
  assign dm_w       = w_q & ~rst;
  assign dm_wdata   = dm_wdata_q;
  assign dm_addr    = {2'b00, addr_q[31:2]};
  assign dm_sc      = `SW_DMEM;
  assign dm_lc      = `LW_DMEM;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural DMEM and strobe monitor.
`ifndef SW_DMEM
`define SW_DMEM 2'b10
`endif
`ifndef LW_DMEM
`define LW_DMEM 3'b010
`endif

module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        dm_cs, dm_r, dm_w;
  logic [1:0]  dm_sc;
  logic [2:0]  dm_lc;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [0:2047];
  logic        preload;
  int          cs_cnt = 0, w_cnt = 0, overlap = 0;
  logic [31:0] last_wdata = 32'h0, last_waddr = 32'h0;

  always #5 clk = ~clk;

  mem_access_unit #(.DMEM_WORDS(2048)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .dm_cs(dm_cs), .dm_r(dm_r), .dm_w(dm_w), .dm_sc(dm_sc), .dm_lc(dm_lc),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
  );

  assign dm_rdata = mem[dm_addr[10:0]];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 2048; i++) mem[i] <= 32'h0;
      mem[8]    <= 32'h1122_3344;
      mem[2047] <= 32'h1234_5678;
    end else if (dm_w) begin
      mem[dm_addr[10:0]] <= dm_wdata;
    end
  end

  always @(negedge clk) begin
    if (dm_cs) cs_cnt++;
    if (dm_r && dm_w) overlap++;
    if (dm_w) begin
      w_cnt++;
      last_wdata = dm_wdata;
      last_waddr = dm_addr;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic xact(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] wd, input int exp_lat,
                      input logic [31:0] exp_rd, input logic exp_err,
                      input int exp_cs, input int exp_w);
    int lat, cs0, w0;
    logic [31:0] rd;
    logic er;
    lat = 0; rd = 32'h0; er = 1'b0;
    @(negedge clk);
    chk({tag, ".ready"}, 32'(req_ready), 32'd1);
    req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    cs0 = cs_cnt; w0 = w_cnt;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= 8 && lat == 0; k++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = k; rd = resp_rdata; er = resp_err;
      end
    end
    chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".rdata"}, rd, exp_rd);
    chk({tag, ".err"}, 32'(er), 32'(exp_err));
    chk({tag, ".cs_cycles"}, 32'(cs_cnt - cs0), 32'(exp_cs));
    chk({tag, ".w_cycles"}, 32'(w_cnt - w0), 32'(exp_w));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, rsp;
    rst = 1'b1; preload = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1 preload = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst.ready", 32'(req_ready), 32'd1);
    chk("rst.resp_valid", 32'(resp_valid), 32'd0);
    chk("rst.rdata", resp_rdata, 32'h0);
    chk("rst.err", 32'(resp_err), 32'd0);
    chk("rst.strobes", {29'h0, dm_cs, dm_r, dm_w}, 32'h0);
    chk("rst.wdata", dm_wdata, 32'h0);
    chk("rst.addr", dm_addr, 32'h0);
    chk("const.sc", 32'(dm_sc), 32'(`SW_DMEM));
    chk("const.lc", 32'(dm_lc), 32'(`LW_DMEM));

    xact("sw10", 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 2, 32'h0, 1'b0, 1, 1);
    chk("sw10.waddr", last_waddr, 32'd4);
    chk("sw10.mem", mem[4], 32'hDEAD_BEEF);
    xact("lw10", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 2, 32'hDEAD_BEEF, 1'b0, 1, 0);

    xact("sb11", 1'b1, 2'd0, 1'b0, 32'h11, 32'h0000_007F, 3, 32'h0, 1'b0, 2, 1);
    chk("sb11.wdata", last_wdata, 32'hDEAD_7FEF);
    xact("lb11", 1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 2, 32'h0000_007F, 1'b0, 1, 0);
    xact("lb13", 1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 2, 32'hFFFF_FFDE, 1'b0, 1, 0);
    xact("lbu13", 1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 2, 32'h0000_00DE, 1'b0, 1, 0);

    xact("sw10b", 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 2, 32'h0, 1'b0, 1, 1);
    xact("sh12", 1'b1, 2'd1, 1'b0, 32'h12, 32'hFFFF_8001, 3, 32'h0, 1'b0, 2, 1);
    chk("sh12.mem", mem[4], 32'h8001_BEEF);
    xact("lh12", 1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 2, 32'hFFFF_8001, 1'b0, 1, 0);
    xact("lhu12", 1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 2, 32'h0000_8001, 1'b0, 1, 0);

    xact("lw13", 1'b0, 2'd2, 1'b0, 32'h13, 32'h0, 1, 32'h0, 1'b1, 0, 0);
    xact("sh01", 1'b1, 2'd1, 1'b0, 32'h01, 32'hFFFF, 1, 32'h0, 1'b1, 0, 0);
    xact("size3", 1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 1, 32'h0, 1'b1, 0, 0);
    xact("lw2000", 1'b0, 2'd2, 1'b0, 32'h2000, 32'h0, 1, 32'h0, 1'b1, 0, 0);
    chk("sh01.mem0", mem[0], 32'h0);
    xact("lw1ffc", 1'b0, 2'd2, 1'b0, 32'h1FFC, 32'h0, 2, 32'h1234_5678, 1'b0, 1, 0);

    // Reset landing in the WR cycle of a byte store.
    @(negedge clk);
    req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0; req_addr = 32'h20;
    req_wdata = 32'h0000_00AA; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rstwr.cs", 32'(dm_cs), 32'd1);
    chk("rstwr.dm_w", 32'(dm_w), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rstwr.ready", 32'(req_ready), 32'd1);
    chk("rstwr.resp_valid", 32'(resp_valid), 32'd0);
    chk("rstwr.mem", mem[8], 32'h1122_3344);

    // Back-to-back loads with req_valid held high.
    acc = 0; rsp = 0;
    req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h10;
    req_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      chk("b2b.ready", 32'(req_ready), (i % 3 == 0) ? 32'd1 : 32'd0);
      if (req_ready) acc++;
      if (resp_valid) begin
        rsp++;
        chk("b2b.rdata", resp_rdata, 32'h8001_BEEF);
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("b2b.accepts", 32'(acc), 32'd4);
    chk("b2b.resps", 32'(rsp), 32'd4);
    repeat (3) @(negedge clk);
    chk("rw_overlap", 32'(overlap), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter DMEM_WORDS, default 2048, giving the number of 32-bit words in DMEM; valid word indices are 0..DMEM_WORDS-1.
REQ-002 SHALL have ports as follows (clock and reset first):
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  CPU request present.
- req_ready  out  1  unit accepts a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal.
- req_unsigned  in  1  zero-extend sub-word loads.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load result, extended; 0 for stores and errors.
- resp_err  out  1  misaligned, illegal size, or out-of-range access; valid with resp_valid.
- dm_cs, dm_r, dm_w  out  1 each  DMEM chip select, read enable, write enable.
- dm_sc  out  2  store class; always `sw_dmem.
- dm_lc  out  3  load class; always `lw_dmem.
- dm_addr  out  32  word index, equal to {2'b0, req_addr[31:2]}.
- dm_wdata  out  32  full word to write.
- dm_rdata  in  32  combinational DMEM read data.

Function
REQ-003 SHALL implement states IDLE, RD, WR, RESP.
REQ-004 SHALL drive req_ready=1 only in IDLE and SHALL ignore req_valid in every other state.
REQ-005 SHALL accept a request on a clk edge where the state is IDLE and req_valid=1, latching req_we, req_size, req_unsigned, req_addr and req_wdata; DMEM outputs SHALL be driven from the latched copies only.
REQ-006 SHALL flag an error when any of the following holds: req_size=3; req_size=1 and addr[0]=1; req_size=2 and addr[1:0]≠0; addr[31:2] ≥ DMEM_WORDS.
REQ-007 On an error, SHALL go from IDLE directly to RESP with resp_err=1 and resp_rdata=0, and SHALL issue no DMEM access.
REQ-008 Load path: SHALL go IDLE→RD→RESP.
- In RD: dm_cs=1 and dm_r=1; dm_rdata is captured at the end of RD.
- In RESP: SHALL output the captured lane shifted right by 8×addr[1:0], then sign-extended or zero-extended per req_unsigned and req_size.
REQ-009 Word store: SHALL go IDLE→WR→RESP, with dm_cs=1, dm_w=1 and dm_wdata=req_wdata in WR.
REQ-010 Byte or half store: SHALL go IDLE→RD→WR→RESP (read-modify-write).
- In WR, dm_wdata SHALL be the captured word with only the addressed lane(s) replaced by req_wdata[7:0] or req_wdata[15:0].
- All other bytes SHALL be unchanged.
REQ-011 Latency from the accept edge at cycle N:
- load: resp_valid during cycle N+2;
- word store: N+2;
- sub-word store: N+3;
- error: N+1.
REQ-012 SHALL hold resp_valid=1 for exactly one cycle (RESP), then return to IDLE; the next request can be accepted the cycle after RESP.
REQ-013 SHALL drive dm_cs=dm_r=dm_w=0 and dm_wdata=0 in IDLE and RESP.
REQ-014 dm_r and dm_w SHALL never both be 1 in the same cycle.
REQ-015 SHALL drive dm_sc=`sw_dmem and dm_lc=`lw_dmem constantly; lane selection is done only inside this unit.
REQ-016 dm_addr SHALL hold the latched word index for the whole transaction.

Reset
REQ-017 With rst=1 at a rising edge, the state SHALL become IDLE and all latched fields SHALL clear to 0.
REQ-018 Output values after reset: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, dm_cs/dm_r/dm_w=0, dm_wdata=0, dm_addr=0.
REQ-019 dm_w SHALL be gated by !rst, so no DMEM write occurs in any cycle where rst=1, including a reset asserted in WR.
REQ-020 rst SHALL take priority over an accept in the same cycle.

Verification
REQ-021 The bench SHALL cover the following directed scenarios:
- Word store 0xDEADBEEF @0x10, then lw @0x10 → dm_w for one cycle at word 4; load returns 0xDEADBEEF with resp_valid at N+2 and resp_err=0.
- sb 0x7F @0x11 over word 0xDEADBEEF → dm_wdata=0xDEAD7FEF at N+2; lb @0x11 returns 0x0000007F.
- sh 0x8001 @0x12 → word becomes 0x8001BEEF; lh @0x12 returns 0xFFFF8001; lhu returns 0x00008001.
- lw @0x13, sh @0x01, size=3, addr=0x2000 (word 2048) → each gives resp_err=1 at N+1, resp_rdata=0, and no DMEM strobe.
- rst asserted during WR of sb @0x20 → no dm_w in the rst cycle; memory word unchanged; req_ready=1 the next cycle.
- req_valid held high across back-to-back loads → accepts exactly one per 3 cycles (IDLE, RD, RESP) with no dropped or duplicated response.
